// File: rtl/axi4stream_output_buffer.sv
`default_nettype none
// ============================================================================
// Module   : axi4stream_output_buffer
// Brief    : Latches one wide parallel word on a load/ready handshake and
//            emits it as an AXI4-Stream master, LS chunk first, with tlast.
//            Optional macro AXIS_OUT_PINGPONG_EN adds a holding register so a
//            second word can queue for zero-bubble back-to-back streaming.
// Revision : 1.0 - initial release
// ============================================================================
module axi4stream_output_buffer #(
    parameter int AXI_WIDTH    = 64,
    parameter int BUFFER_WIDTH = 256
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [BUFFER_WIDTH-1:0] myBuffer,
    input  logic                    load,
    output logic                    ready,
    output logic [AXI_WIDTH-1:0]    tdata,
    output logic                    tvalid,
    output logic                    tlast,
    input  logic                    tready
);

    localparam int NUM_BEATS = (BUFFER_WIDTH + AXI_WIDTH - 1) / AXI_WIDTH;
    localparam int c_PAD_W   = NUM_BEATS * AXI_WIDTH;
    localparam int c_BEAT_W  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(NUM_BEATS - 1);
    localparam logic c_SINGLE = (NUM_BEATS == 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t              state_q;
    logic [c_BEAT_W-1:0] beat_q;
    logic [c_PAD_W-1:0]  data_q;
    logic                ready_q;
    logic                tvalid_q;
    logic                tlast_q;

    logic [c_PAD_W-1:0]  w_in;
    logic [c_PAD_W-1:0]  w_shifted;
    logic [c_BEAT_W-1:0] w_beat_next;

    // The incoming word is zero-extended to a whole number of beats so the
    // final partial chunk comes out with zeros above the real bits.
    generate
        if (c_PAD_W > BUFFER_WIDTH) begin : g_pad
            assign w_in = {{(c_PAD_W - BUFFER_WIDTH){1'b0}}, myBuffer};
        end else begin : g_nopad
            assign w_in = myBuffer;
        end

        if (NUM_BEATS > 1) begin : g_shift
            assign w_shifted = {{AXI_WIDTH{1'b0}}, data_q[c_PAD_W-1:AXI_WIDTH]};
        end else begin : g_noshift
            assign w_shifted = data_q;
        end
    endgenerate

    assign w_beat_next = beat_q + 1'b1;

`ifdef AXIS_OUT_PINGPONG_EN
    logic [c_PAD_W-1:0] hold_q;
    logic               hold_full_q;
    logic               w_hold_cap;

    // A word arriving mid-stream parks in the holding register unless the
    // current word is finishing this very edge, in which case it goes direct.
    assign w_hold_cap = load & ready_q & (state_q == S_STREAM) & ~(tready & tlast_q);
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            data_q      <= '0;
            ready_q     <= 1'b1;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
`ifdef AXIS_OUT_PINGPONG_EN
            hold_q      <= '0;
            hold_full_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        data_q   <= w_in;
                        beat_q   <= '0;
                        tlast_q  <= c_SINGLE;
                        tvalid_q <= 1'b1;
                        state_q  <= S_STREAM;
`ifndef AXIS_OUT_PINGPONG_EN
                        ready_q  <= 1'b0;
`endif
                    end
                end
                S_STREAM: begin
                    if (tready) begin
                        if (tlast_q) begin
`ifdef AXIS_OUT_PINGPONG_EN
                            if (hold_full_q) begin
                                data_q      <= hold_q;
                                beat_q      <= '0;
                                tlast_q     <= c_SINGLE;
                                hold_full_q <= 1'b0;
                                ready_q     <= 1'b1;
                            end else if (load) begin
                                data_q  <= w_in;
                                beat_q  <= '0;
                                tlast_q <= c_SINGLE;
                            end else begin
                                state_q  <= S_IDLE;
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                            end
`else
                            state_q  <= S_IDLE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            ready_q  <= 1'b1;
`endif
                        end else begin
                            data_q  <= w_shifted;
                            beat_q  <= w_beat_next;
                            tlast_q <= (w_beat_next == c_LAST_BEAT);
                        end
                    end
`ifdef AXIS_OUT_PINGPONG_EN
                    if (w_hold_cap) begin
                        hold_q      <= w_in;
                        hold_full_q <= 1'b1;
                        ready_q     <= 1'b0;
                    end
`endif
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign tvalid = tvalid_q;
    assign tlast  = tlast_q;
    assign tdata  = data_q[AXI_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_axi4stream_output_buffer.sv
`default_nettype none
// Scoreboarded bench for axi4stream_output_buffer: directed cases plus random
// load/backpressure, with side instances for a 160-bit and a single-beat word.
module tb_axi4stream_output_buffer;

    localparam int AW = 64;
    localparam int BW = 256;
    localparam int NB = 4;
`ifdef AXIS_OUT_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          areset;
    logic [BW-1:0] myBuffer;
    logic          load, ready, tvalid, tlast, tready;
    logic [AW-1:0] tdata;

    logic [159:0]  myBuffer2;
    logic          load2, ready2, tvalid2, tlast2, tready2;
    logic [AW-1:0] tdata2;

    logic [31:0]   myBuffer3;
    logic          load3, ready3, tvalid3, tlast3, tready3;
    logic [AW-1:0] tdata3;

    always #5 aclk = ~aclk;

    axi4stream_output_buffer #(.AXI_WIDTH(AW), .BUFFER_WIDTH(BW)) dut (
        .aclk(aclk), .areset(areset), .myBuffer(myBuffer), .load(load), .ready(ready),
        .tdata(tdata), .tvalid(tvalid), .tlast(tlast), .tready(tready)
    );
    axi4stream_output_buffer #(.AXI_WIDTH(AW), .BUFFER_WIDTH(160)) dut2 (
        .aclk(aclk), .areset(areset), .myBuffer(myBuffer2), .load(load2), .ready(ready2),
        .tdata(tdata2), .tvalid(tvalid2), .tlast(tlast2), .tready(tready2)
    );
    axi4stream_output_buffer #(.AXI_WIDTH(AW), .BUFFER_WIDTH(32)) dut3 (
        .aclk(aclk), .areset(areset), .myBuffer(myBuffer3), .load(load3), .ready(ready3),
        .tdata(tdata3), .tvalid(tvalid3), .tlast(tlast3), .tready(tready3)
    );

    typedef struct packed {
        logic [AW-1:0] d;
        logic          l;
    } beat_t;

    beat_t q[$];
    int    words_out = 0;
    int    total = 0;
    int    bad = 0;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit exp_ready();
        return PP ? (words_out < 2) : (words_out == 0);
    endfunction

    function automatic logic [BW-1:0] rand_word();
        logic [BW-1:0] w;
        for (int i = 0; i < BW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic push_word(input logic [BW-1:0] word);
        logic [BW-1:0] tmp;
        beat_t b;
        for (int k = 0; k < NB; k++) begin
            tmp = word >> (k * AW);
            b.d = tmp[AW-1:0];
            b.l = (k == NB - 1);
            q.push_back(b);
        end
        words_out++;
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_load(input logic [BW-1:0] word);
        bit er;
        myBuffer = word;
        load     = 1'b1;
        er       = exp_ready();
        chk("ready_vs_model", BW'(ready), BW'(er));
        if (er) push_word(word);
    endtask

    task automatic send(input logic [BW-1:0] word);
        drive_load(word);
        step();
        load = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 200 && q.size() != 0; i++) begin
            tready = 1'b1;
            step();
        end
        chk({nm, "_drained"}, BW'(q.size()), '0);
        chk({nm, "_idle_ready"}, BW'(ready), BW'(1));
        chk({nm, "_idle_tvalid"}, BW'(tvalid), '0);
    endtask

    // Monitor: pops expected beats on each handshake and checks stability while stalled.
    logic          pend = 1'b0;
    logic [AW-1:0] pd;
    logic          pl;
    always @(negedge aclk) begin
        beat_t e;
        if (areset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("stall_tvalid", BW'(tvalid), BW'(1));
                chk("stall_tdata", BW'(tdata), BW'(pd));
                chk("stall_tlast", BW'(tlast), BW'(pl));
            end
            if (tvalid && tready) begin
                chk("beat_expected", BW'(q.size() != 0), BW'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("beat_tdata", BW'(tdata), BW'(e.d));
                    chk("beat_tlast", BW'(tlast), BW'(e.l));
                    if (e.l) words_out--;
                end
                pend = 1'b0;
            end else if (tvalid) begin
                pend = 1'b1;
                pd   = tdata;
                pl   = tlast;
            end else begin
                pend = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [BW-1:0]  w1, w2;
        logic [191:0]   exp2;
        int             pat [7];
        pat = '{1, 0, 0, 1, 0, 1, 1};
        w1  = {64'd4, 64'd3, 64'd2, 64'd1};
        w2  = {64'hD0D0, 64'hC0C0, 64'hB0B0, 64'hA0A0};

        areset = 1'b1; load = 1'b0; tready = 1'b0; myBuffer = '0;
        load2 = 1'b0; tready2 = 1'b1; myBuffer2 = '0;
        load3 = 1'b0; tready3 = 1'b0; myBuffer3 = '0;
        step(); step();
        areset = 1'b0;

        chk("rst_ready", BW'(ready), BW'(1));
        chk("rst_tvalid", BW'(tvalid), '0);
        chk("rst_tlast", BW'(tlast), '0);
        chk("rst_tdata", BW'(tdata), '0);

        // 160-bit word: two full beats then a zero-padded partial beat.
        myBuffer2 = '1; load2 = 1'b1;
        step();
        load2 = 1'b0;
        exp2 = {32'b0, {160{1'b1}}};
        for (int k = 0; k < 3; k++) begin
            chk("w160_tvalid", BW'(tvalid2), BW'(1));
            chk("w160_tdata", BW'(tdata2), BW'(exp2[k*64 +: 64]));
            chk("w160_tlast", BW'(tlast2), BW'(k == 2));
            step();
        end
        chk("w160_idle_tvalid", BW'(tvalid2), '0);
        chk("w160_idle_ready", BW'(ready2), BW'(1));

        // Single-beat word held through a stall.
        myBuffer3 = 32'hDEADBEEF; load3 = 1'b1;
        step();
        load3 = 1'b0;
        chk("w32_tdata", BW'(tdata3), BW'(64'h00000000DEADBEEF));
        chk("w32_tlast", BW'(tlast3), BW'(1));
        step();
        chk("w32_hold_tvalid", BW'(tvalid3), BW'(1));
        chk("w32_hold_tlast", BW'(tlast3), BW'(1));
        tready3 = 1'b1;
        step();
        chk("w32_idle_tvalid", BW'(tvalid3), '0);
        chk("w32_idle_ready", BW'(ready3), BW'(1));

        // Basic four-beat word with tready high.
        tready = 1'b1;
        send(w1);
        chk("t1_latency_tvalid", BW'(tvalid), BW'(1));
        chk("t1_first_tdata", BW'(tdata), BW'(64'd1));
        drain("t1");

        // Backpressure pattern.
        tready = 1'b0;
        send(w1);
        for (int i = 0; i < 7; i++) begin
            tready = pat[i][0];
            step();
        end
        chk("t3_handshakes", BW'(q.size()), '0);
        chk("t3_ready_after", BW'(ready), BW'(1));

        // Load pulsed while beat 2 is pending.
        tready = 1'b1;
        send(w1);
        step(); step();
        tready = 1'b0;
        drive_load(w2);
        step();
        load = 1'b0;
        drain("t4");

        // Reset mid-word, then a fresh word from chunk 0.
        tready = 1'b1;
        send(w1);
        step();
        tready = 1'b0;
        step();
        areset = 1'b1;
        q.delete();
        words_out = 0;
        step();
        areset = 1'b0;
        chk("t5_rst_tvalid", BW'(tvalid), '0);
        chk("t5_rst_ready", BW'(ready), BW'(1));
        tready = 1'b1;
        send(w2);
        chk("t5_restart_tdata", BW'(tdata), BW'(64'hA0A0));
        drain("t5");

        // Back-to-back words.
        tready = 1'b1;
        send(w1);
        for (int i = 0; i < 8; i++) begin
`ifdef AXIS_OUT_PINGPONG_EN
            chk("t6_no_bubble", BW'(tvalid), BW'(1));
`endif
            if (i == 0) drive_load(w2);
            step();
            load = 1'b0;
        end
        drain("t6");

        // Random loads and backpressure.
        for (int i = 0; i < 400; i++) begin
            tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) drive_load(rand_word());
            step();
            load = 1'b0;
        end
        drain("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
